// File: rtl/pcn_pkg.sv
// Shared definitions for the next-PC predictor.
// Holds the control-transfer class codes, the branch-type codes (funct3),
// the branch counter type with its reset value, and the counter update helper.
package pcn_pkg;

  // Control-transfer class carried with each instruction; any other value is non-control
  localparam logic [2:0] S_BR   = 3'd1;
  localparam logic [2:0] S_JAL  = 3'd2;
  localparam logic [2:0] S_JALR = 3'd3;

  // Conditional branch types (RV64I funct3)
  localparam logic [2:0] B_EQ  = 3'b000;
  localparam logic [2:0] B_NE  = 3'b001;
  localparam logic [2:0] B_LT  = 3'b100;
  localparam logic [2:0] B_GE  = 3'b101;
  localparam logic [2:0] B_LTU = 3'b110;
  localparam logic [2:0] B_GEU = 3'b111;

  localparam int unsigned PERF_W = 32;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t WEAK_NT = 2'b01;

  // 2-bit saturating counter step
  function automatic bht_ctr_t ctr_update(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t res;
    res = ctr;
    if (taken && ctr != 2'b11) res = ctr + 2'(1);
    else if (!taken && ctr != 2'b00) res = ctr - 2'(1);
    return res;
  endfunction

endpackage

// File: rtl/pcn_bht.sv
// Branch history table: DEPTH 2-bit saturating counters.
// Ports: clk/rst (async active-high), rd_idx/rd_ctr asynchronous read,
// upd_en/upd_idx/upd_taken synchronous update. A read at the index being
// updated in the same cycle returns the pre-update value.
module pcn_bht
  import pcn_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  bht_ctr_t ctr_q [DEPTH];

  // Counter array with single update port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) ctr_q[i] <= WEAK_NT;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= ctr_update(ctr_q[upd_idx], upd_taken);
    end
  end

  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/pcn_predict.sv
// Next-PC generator: fetch PC register, decode-time branch prediction from a
// counter table, execute-time resolution with redirect and flush requests.
// Ports: clk/rst (async active-high); if_ready, pc (fetch); id_* (decode
// prediction, id_pred_taken); ex_* (resolution); flush_if/flush_id;
// perf_branches/perf_mispredicts.
// Define PCN_PERF_EN to build the saturating perf counters; otherwise the
// perf ports read 0.
module pcn_predict
  import pcn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BHT_DEPTH  = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(64'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] pc,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [2:0]            id_specinst,
  input  logic [DATA_WIDTH-1:0] id_target,
  output logic                  id_pred_taken,
  input  logic                  ex_valid,
  input  logic [2:0]            ex_specinst,
  input  logic [2:0]            ex_detail,
  input  logic                  ex_cmp,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_take_target,
  input  logic                  ex_pred_taken,
  output logic                  flush_if,
  output logic                  flush_id,
  output logic [PERF_W-1:0]     perf_branches,
  output logic [PERF_W-1:0]     perf_mispredicts
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  logic [IDX_W-1:0]      id_idx;
  logic [IDX_W-1:0]      ex_idx;
  bht_ctr_t              id_ctr;
  logic                  ex_br;
  logic                  ex_actual;
  logic                  ex_redirect;
  logic                  id_redirect;
  logic [DATA_WIDTH-1:0] ex_target;
  logic [DATA_WIDTH-1:0] pc_next;
  logic                  unused_id_pc;

  assign id_idx = id_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  // Only the index bits of the decode PC feed the table
  assign unused_id_pc = ^{id_pc[DATA_WIDTH-1:IDX_W+2], id_pc[1:0]};

  pcn_bht #(.DEPTH(BHT_DEPTH)) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (id_idx),
    .rd_ctr    (id_ctr),
    .upd_en    (ex_br),
    .upd_idx   (ex_idx),
    .upd_taken (ex_actual)
  );

  // Decode prediction: JAL always taken, JALR never, BR from counter MSB
  assign id_pred_taken = id_valid &
                         ((id_specinst == S_JAL) | ((id_specinst == S_BR) & id_ctr[1]));
  assign id_redirect   = id_pred_taken;

  assign ex_br = ex_valid & (ex_specinst == S_BR);

  // Resolve actual direction; undefined branch types resolve not-taken
  always_comb begin
    ex_actual = 1'b0;
    if (ex_specinst == S_JAL || ex_specinst == S_JALR) begin
      ex_actual = 1'b1;
    end else if (ex_specinst == S_BR) begin
      case (ex_detail)
        B_EQ, B_LT, B_LTU:  ex_actual = ex_cmp;
        B_NE, B_GE, B_GEU:  ex_actual = ~ex_cmp;
        default:            ex_actual = 1'b0;
      endcase
    end
  end

  assign ex_redirect = ex_valid & (((ex_specinst == S_BR) & (ex_actual != ex_pred_taken)) |
                                   (ex_specinst == S_JALR));
  assign ex_target   = ex_actual ? ex_take_target : ex_pc + PC_STEP;

  assign flush_if = ex_redirect | id_redirect;
  assign flush_id = ex_redirect;

  // Execute redirect overrides decode redirect, which overrides sequential fetch
  always_comb begin
    pc_next = pc;
    if (ex_redirect)      pc_next = ex_target;
    else if (id_redirect) pc_next = id_target;
    else if (if_ready)    pc_next = pc + PC_STEP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

`ifdef PCN_PERF_EN
  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (ex_br && perf_branches != '1)
        perf_branches <= perf_branches + PERF_W'(1);
      if (ex_br && ex_redirect && perf_mispredicts != '1)
        perf_mispredicts <= perf_mispredicts + PERF_W'(1);
    end
  end
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_pcn_predict.sv
// Bench for pcn_predict: directed per-cycle vectors; expectations are queued
// tagged with the cycle they apply to and checked by a separate monitor at
// the falling edge.
module tb_pcn_predict;
  import pcn_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_ready = 1'b0;
  logic [63:0] pc;
  logic        id_valid = 1'b0;
  logic [63:0] id_pc = '0;
  logic [2:0]  id_specinst = '0;
  logic [63:0] id_target = '0;
  logic        id_pred_taken;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_specinst = '0;
  logic [2:0]  ex_detail = '0;
  logic        ex_cmp = 1'b0;
  logic [63:0] ex_pc = '0;
  logic [63:0] ex_take_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic        flush_if;
  logic        flush_id;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  pcn_predict dut (
    .clk(clk), .rst(rst), .if_ready(if_ready), .pc(pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_specinst(id_specinst),
    .id_target(id_target), .id_pred_taken(id_pred_taken),
    .ex_valid(ex_valid), .ex_specinst(ex_specinst), .ex_detail(ex_detail),
    .ex_cmp(ex_cmp), .ex_pc(ex_pc), .ex_take_target(ex_take_target),
    .ex_pred_taken(ex_pred_taken), .flush_if(flush_if), .flush_id(flush_id),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      case (e.sel)
        0:       act = pc;
        1:       act = 64'(id_pred_taken);
        2:       act = 64'(flush_if);
        3:       act = 64'(flush_id);
        4:       act = 64'(perf_branches);
        default: act = 64'(perf_mispredicts);
      endcase
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL %s cyc=%0d not sampled in time (now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.exp) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.name, e.cyc, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int sel, input logic [63:0] v);
    exp_t e;
    e.cyc = cyc; e.name = name; e.sel = sel; e.exp = v;
    q.push_back(e);
  endtask

  task automatic flags(input string tag, input logic p, input logic fi, input logic fd);
    chk({tag, "_pred"}, 1, 64'(p));
    chk({tag, "_flush_if"}, 2, 64'(fi));
    chk({tag, "_flush_id"}, 3, 64'(fd));
  endtask

  task automatic clr();
    id_valid = 1'b0; id_pc = '0; id_specinst = '0; id_target = '0;
    ex_valid = 1'b0; ex_specinst = '0; ex_detail = '0; ex_cmp = 1'b0;
    ex_pc = '0; ex_take_target = '0; ex_pred_taken = 1'b0;
  endtask

  task automatic id_drv(input logic [2:0] s, input logic [63:0] p, input logic [63:0] t);
    id_valid = 1'b1; id_specinst = s; id_pc = p; id_target = t;
  endtask

  task automatic ex_drv(input logic [2:0] s, input logic [2:0] d, input logic c,
                        input logic [63:0] p, input logic [63:0] t, input logic pr);
    ex_valid = 1'b1; ex_specinst = s; ex_detail = d; ex_cmp = c;
    ex_pc = p; ex_take_target = t; ex_pred_taken = pr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pb, exp_pm;
`ifdef PCN_PERF_EN
    exp_pb = 32'd6; exp_pm = 32'd4;
`else
    exp_pb = 32'd0; exp_pm = 32'd0;
`endif
    // 1: reset state, release with sequential fetch
    step();
    rst = 1'b0; if_ready = 1'b1;
    chk("rst_pc", 0, RST_PC);
    flags("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_perf_b", 4, 64'd0);
    chk("rst_perf_m", 5, 64'd0);
    // 2
    step(); chk("seq_pc1", 0, 64'h8000_0004);
    // 3: JAL at decode while fetch stalled
    step(); chk("seq_pc2", 0, 64'h8000_0008);
    if_ready = 1'b0;
    id_drv(S_JAL, 64'h8000_0008, 64'h8000_0100);
    flags("jal", 1'b1, 1'b1, 1'b0);
    // 4: cold BR EQ mispredict; decode at same index reads old counter
    step(); chk("jal_pc", 0, 64'h8000_0100);
    clr();
    ex_drv(S_BR, B_EQ, 1'b1, 64'h8000_0010, 64'h8000_0040, 1'b0);
    id_drv(S_BR, 64'h8000_0010, 64'h8000_0500);
    flags("beq1", 1'b0, 1'b1, 1'b1);
    // 5: second resolve; decode now sees weakly taken but ex wins
    step(); chk("beq1_pc", 0, 64'h8000_0040);
    flags("beq2", 1'b1, 1'b1, 1'b1);
    // 6: decode alone predicts taken
    step(); chk("beq2_pc", 0, 64'h8000_0040);
    clr();
    id_drv(S_BR, 64'h8000_0010, 64'h8000_0500);
    flags("warm", 1'b1, 1'b1, 1'b0);
    // 7: BR GE predicted taken, cmp=1 -> not taken, redirect to pc+4 (3->2)
    step(); chk("warm_pc", 0, 64'h8000_0500);
    clr();
    ex_drv(S_BR, B_GE, 1'b1, 64'h8000_0010, 64'h8000_0040, 1'b1);
    flags("bge", 1'b0, 1'b1, 1'b1);
    // 8: correct not-taken resolve (2->1); decode still reads 2
    step(); chk("bge_pc", 0, 64'h8000_0014);
    clr();
    ex_drv(S_BR, B_GE, 1'b1, 64'h8000_0010, 64'h8000_0040, 1'b0);
    id_drv(S_BR, 64'h8000_0010, 64'h8000_0600);
    flags("bge_ok", 1'b1, 1'b1, 1'b0);
    // 9: counter now 1 -> not predicted; stalled fetch holds pc
    step(); chk("bge_ok_pc", 0, 64'h8000_0600);
    clr();
    id_drv(S_BR, 64'h8000_0010, 64'h8000_0700);
    flags("dec", 1'b0, 1'b0, 1'b0);
    // 10: ex JALR and decode JAL in same cycle
    step(); chk("hold_pc", 0, 64'h8000_0600);
    clr();
    ex_drv(S_JALR, 3'b000, 1'b0, 64'h8000_0700, 64'h8000_2000, 1'b0);
    id_drv(S_JAL, 64'h8000_0800, 64'h8000_0300);
    flags("prio", 1'b1, 1'b1, 1'b1);
    // 11: decode JALR not predicted; correct BNE taken
    step(); chk("prio_pc", 0, 64'h8000_2000);
    clr(); if_ready = 1'b1;
    id_drv(S_JALR, 64'h8000_0900, 64'h8000_0a00);
    ex_drv(S_BR, B_NE, 1'b0, 64'h8000_0020, 64'h8000_0080, 1'b1);
    flags("bne", 1'b0, 1'b0, 1'b0);
    // 12: undefined branch type resolves not taken
    step(); chk("bne_pc", 0, 64'h8000_2004);
    clr();
    ex_drv(S_BR, 3'b010, 1'b1, 64'h8000_0030, 64'h8000_00c0, 1'b1);
    flags("undef", 1'b0, 1'b1, 1'b1);
    // 13: perf totals; JALR to top of address space
    step(); chk("undef_pc", 0, 64'h8000_0034);
    chk("perf_b", 4, 64'(exp_pb));
    chk("perf_m", 5, 64'(exp_pm));
    clr();
    ex_drv(S_JALR, 3'b000, 1'b0, 64'h8000_0800, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    flags("jalr", 1'b0, 1'b1, 1'b1);
    // 14
    step(); chk("top_pc", 0, 64'hFFFF_FFFF_FFFF_FFFC);
    clr();
    // 15: pc+4 wraps
    step(); chk("wrap_pc", 0, 64'h0);
    // 16: reset mid-operation with a redirect request
    step();
    rst = 1'b1;
    ex_drv(S_JALR, 3'b000, 1'b0, 64'h8000_0000, 64'h8000_0900, 1'b0);
    chk("arst_pc", 0, RST_PC);
    // 17
    step();
    clr(); rst = 1'b0; if_ready = 1'b0;
    chk("arst_pc2", 0, RST_PC);
    flags("arst", 1'b0, 1'b0, 1'b0);
    chk("arst_perf_b", 4, 64'd0);
    chk("arst_perf_m", 5, 64'd0);
    // 18: table back to weakly not-taken
    step(); chk("post_pc", 0, RST_PC);
    id_drv(S_BR, 64'h8000_0020, 64'h8000_0f00);
    flags("post", 1'b0, 1'b0, 1'b0);
    step(); clr();
    step();
    if (q.size() != 0) begin
      bad += q.size();
      total += q.size();
      $display("FAIL drain %0d expectations unchecked", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
